// File: rtl/mem_arbiter_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_ctrl_if
// Brief    : Requester and memory-side bus bundle for mem_arbiter_ctrl.
// Revision : 1.0
// ============================================================================
interface mem_arbiter_ctrl_if #(
    parameter int N_CH = 4,
    parameter int DW   = 8,
    parameter int AW   = 16
);
    logic [N_CH-1:0]    i_req;
    logic [N_CH-1:0]    i_we;
    logic [N_CH*AW-1:0] i_addr;
    logic [N_CH*DW-1:0] i_wdata;
    logic [N_CH-1:0]    o_gnt;
    logic [N_CH-1:0]    o_rvalid;
    logic [N_CH*DW-1:0] o_rdata;
    logic [AW-1:0]      o_mem_addr;
    logic [DW-1:0]      o_mem_wdata;
    logic               o_mem_rden;
    logic               o_mem_wren;
    logic [DW-1:0]      i_mem_q;
    logic               o_busy;

    modport slave (
        input  i_req, i_we, i_addr, i_wdata, i_mem_q,
        output o_gnt, o_rvalid, o_rdata, o_mem_addr, o_mem_wdata,
               o_mem_rden, o_mem_wren, o_busy
    );

    modport master (
        output i_req, i_we, i_addr, i_wdata, i_mem_q,
        input  o_gnt, o_rvalid, o_rdata, o_mem_addr, o_mem_wdata,
               o_mem_rden, o_mem_wren, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_ctrl
// Brief    : Round-robin arbiter of N_CH requesters onto one synchronous
//            single-port memory, with per-channel read-data return.
// Revision : 1.0
// ============================================================================
module mem_arbiter_ctrl #(
    parameter int N_CH   = 4,
    parameter int DW     = 8,
    parameter int AW     = 16,
    parameter int RD_LAT = 1
) (
    input  wire logic          i_clk,
    input  wire logic          i_rst_n,
    mem_arbiter_ctrl_if.slave  bus
);
    localparam int c_ID_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [c_ID_W-1:0]  r_rr;
    logic [c_ID_W-1:0]  w_idx;
    logic               w_xfer;
    logic [N_CH-1:0]    w_gnt;
    logic               w_rd;
    int                 w_j;

    logic [AW-1:0]      r_mem_addr;
    logic [DW-1:0]      r_mem_wdata;
    logic               r_mem_rden;
    logic               r_mem_wren;
    logic [RD_LAT:0]    r_pv;
    logic [c_ID_W-1:0]  r_pid [0:RD_LAT];
    logic [N_CH-1:0]    r_rvalid;
    logic [N_CH*DW-1:0] r_rdata;

    // First requesting channel at or after the round-robin pointer wins.
    always_comb begin
        w_xfer = 1'b0;
        w_idx  = '0;
        w_j    = 0;
        w_gnt  = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_j = int'(r_rr) + i;
            if (w_j >= N_CH) begin
                w_j = w_j - N_CH;
            end
            if (!w_xfer && bus.i_req[w_j]) begin
                w_xfer = i_rst_n;
                w_idx  = c_ID_W'(w_j);
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            w_gnt[i] = w_xfer && (w_idx == c_ID_W'(i));
        end
    end

    assign w_rd = w_xfer & ~bus.i_we[w_idx];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr        <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_rden  <= 1'b0;
            r_mem_wren  <= 1'b0;
            r_pv        <= '0;
            for (int s = 0; s <= RD_LAT; s++) begin
                r_pid[s] <= '0;
            end
            r_rvalid    <= '0;
            r_rdata     <= '0;
        end else begin
            r_mem_rden <= w_rd;
            r_mem_wren <= w_xfer & bus.i_we[w_idx];
            if (w_xfer) begin
                r_mem_addr  <= bus.i_addr[w_idx*AW +: AW];
                r_mem_wdata <= bus.i_wdata[w_idx*DW +: DW];
                r_rr        <= (w_idx == c_ID_W'(N_CH-1)) ? '0 : w_idx + 1'b1;
            end

            // Stage RD_LAT lines up with the memory's data for that read.
            r_pv     <= {r_pv[RD_LAT-1:0], w_rd};
            r_pid[0] <= w_idx;
            for (int s = 1; s <= RD_LAT; s++) begin
                r_pid[s] <= r_pid[s-1];
            end

            r_rvalid <= '0;
            if (r_pv[RD_LAT]) begin
                for (int k = 0; k < N_CH; k++) begin
                    if (r_pid[RD_LAT] == c_ID_W'(k)) begin
                        r_rvalid[k]          <= 1'b1;
                        r_rdata[k*DW +: DW]  <= bus.i_mem_q;
                    end
                end
            end
        end
    end

    assign bus.o_gnt       = w_gnt;
    assign bus.o_rvalid    = r_rvalid;
    assign bus.o_rdata     = r_rdata;
    assign bus.o_mem_addr  = r_mem_addr;
    assign bus.o_mem_wdata = r_mem_wdata;
    assign bus.o_mem_rden  = r_mem_rden;
    assign bus.o_mem_wren  = r_mem_wren;
    assign bus.o_busy      = |r_pv;
endmodule
`default_nettype wire

// File: doc/mem_arbiter_ctrl.md
# mem_arbiter_ctrl

Parametrised multi-channel memory controller. It arbitrates N_CH independent read/write requesters onto one single-port synchronous memory and returns read data to the channel that issued the read. It replaces fixed four-channel, externally sequenced memory access with a per-channel valid/grant handshake, round-robin fairness and configurable memory read latency. It sits between the matrix-multiplier processing cores and the shared DRAM module.

## Interface
Parameters:
- N_CH, 4: number of requester channels (2..8).
- DW, 8: data width.
- AW, 16: address width.
- RD_LAT, 1: memory read latency in cycles, from command presented to i_mem_q valid (1..4).

Ports:
- i_clk  in  1  single clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req  in  N_CH  per-channel request; held with i_we/i_addr/i_wdata stable until granted.
- i_we  in  N_CH  per-channel access type: 1 = write, 0 = read.
- i_addr  in  N_CH*AW  packed addresses; channel k is at [k*AW +: AW].
- i_wdata  in  N_CH*DW  packed write data; channel k is at [k*DW +: DW].
- o_gnt  out  N_CH  combinational one-hot grant.
- o_rvalid  out  N_CH  one-cycle pulse: o_rdata for that channel is updated.
- o_rdata  out  N_CH*DW  per-channel read-data registers, held between updates.
- o_mem_addr  out  AW  registered memory address.
- o_mem_wdata  out  DW  registered memory write data.
- o_mem_rden  out  1  registered memory read enable.
- o_mem_wren  out  1  registered memory write enable.
- i_mem_q  in  DW  memory read data.
- o_busy  out  1  high while any read is in flight.

## Operation
- Arbitration is round-robin. A registered pointer rr (reset 0) names the highest-priority channel. The granted channel is the first k with i_req[k]=1, searching rr, rr+1, … mod N_CH.
- o_gnt is combinational from i_req and rr. It is all-zero when no request is present or i_rst_n=0, and never has more than one bit set.
- A transfer occurs at a rising edge where i_req[k]&o_gnt[k]=1. At that edge:
  - o_mem_addr and o_mem_wdata load channel k's address and data.
  - o_mem_wren is set to i_we[k] and o_mem_rden to !i_we[k].
  - rr is set to (k+1) mod N_CH.
- At an edge with no transfer, rden and wren clear; address and data hold their last value.
- A requester that holds i_req high after its transfer is treated as a new request and competes under the updated rr.
- Read return tracking:
  - A shift pipeline of RD_LAT+1 stages carries {valid, channel id}, entered at each read transfer.
  - When an entry exits the pipeline, i_mem_q is captured into that channel's o_rdata and o_rvalid for that channel pulses.
- Writes produce no response.
- Commands issue in grant order, so a read after a write to the same address returns the new data.
- o_busy = OR of all pipeline valid bits.
- Reset values:
  - o_rvalid, o_rdata, o_mem_* and o_busy are 0.
  - rr is 0.
  - The pipeline is cleared.
- Reset asserted mid-operation drops all in-flight reads: no o_rvalid may follow for them, and stale i_mem_q is ignored.

## Timing
- Grant is in the same cycle as the request (zero wait when uncontested). Throughput is one transfer per cycle.
- Transfer at edge t: o_mem_* is valid in the cycle after edge t. The memory returns i_mem_q RD_LAT cycles later.
- o_rdata/o_rvalid update at edge t+RD_LAT+1.
- Back-to-back reads from different channels return in issue order, one per cycle, with no bubbles.
- Worst-case wait for a continuously requesting channel is N_CH-1 cycles.
- Simultaneous read-exit and new read-entry in the same cycle are both handled; the pipeline never stalls.
- Parameter changes must not require RTL edits: all widths derive from N_CH, DW, AW and RD_LAT, and the id width is clog2(N_CH), minimum 1.

## Test plan
- Single read, defaults. Memory preloaded with 0x5A at address 0x0010. Ch2 requests a read of 0x0010 at edge 0. Required: o_gnt=4'b0100 in cycle 0; o_mem_rden=1 with address 0x0010 after edge 0; o_rdata[ch2]=0x5A and o_rvalid=4'b0100 after edge 2, for one cycle only.
- Fairness. All four channels hold a read request continuously from reset. Required: grants follow 0,1,2,3,0,1…; four o_rvalid pulses in the same order, one per cycle starting at edge 2.
- Write-then-read. Ch1 writes 0xC3 to address 0x0100 at edge 0, then reads 0x0100 at edge 1. Required: o_mem_wren=1 for one cycle after edge 0; o_rdata[ch1]=0xC3 after edge 3.
- Hogging. Ch0 holds its request continuously and ch3 requests at edge 2. Required: ch3 is granted no later than edge 3, after which ch0 resumes.
- Reset mid-flight. Assert i_rst_n low one cycle after a read transfer. Required: all outputs 0 immediately and asynchronously; no o_rvalid after release; rr=0.
- Parameter sweep. N_CH=2, DW=16, AW=10, RD_LAT=3. A ch1 read of a location holding 0xBEEF returns o_rdata[ch1]=0xBEEF at edge t+4; o_busy is high from after edge t until after edge t+4.
